// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and types for the packet-buffer SRAM
// (16K x 16, one write port, one read port).
//   ADDR_W     : SRAM address width
//   DATA_W     : SRAM data width
//   SRAM_DEPTH : number of SRAM words
//   addr_t     : SRAM address type
//   data_t     : SRAM data type
package sram_pkg;
   localparam int ADDR_W     = 14;
   localparam int DATA_W     = 16;
   localparam int SRAM_DEPTH = 16384;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
endpackage : sram_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a registered priority pointer.
// The grant is combinational from req and the pointer. The search starts at
// ptr and wraps modulo N, and the first requester found wins. After a grant to
// port k the pointer moves to (k+1) mod N; with no grant it holds.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset; clears the pointer and forces gnt to 0
//   req : per-port request
//   gnt : one-hot grant (all zero when nothing is granted)
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] win;
   logic [PTR_W:0]   sum;
   logic             found;

   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int i = 0; i < N; i++) begin
         // ptr < N and i < N, so one conditional subtract gives (ptr+i) mod N.
         sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(N)) begin
            sum = sum - (PTR_W+1)'(N);
         end
         if (!found && req[sum[PTR_W-1:0]]) begin
            found = 1'b1;
            win   = sum[PTR_W-1:0];
         end
      end
      // Reset forces the grant low right away, so no transfer starts during reset.
      if (rst) begin
         found = 1'b0;
      end
      gnt   = '0;
      ptr_d = ptr_q;
      if (found) begin
         gnt[win] = 1'b1;
         if (win == PTR_W'(N-1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule : rr_arbiter

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-write/single-read SRAM among N_PORTS
// requesters. The write path and the read path each use an independent
// round-robin arbiter, so the block grants at most one write and one read per
// cycle.
// Handshake: a requester holds req/addr/data stable until it sees gnt in the
// same cycle. The transfer completes at the clock edge that ends that cycle.
// Read data comes back one cycle after the grant, flagged by a one-hot rd_vld
// on the shared rd_data bus.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data      : per-port write requests (port k at slice k)
//   wr_gnt                      : one-hot write grant
//   rd_req/rd_addr              : per-port read requests
//   rd_gnt                      : one-hot read grant
//   rd_vld/rd_data              : read return, valid one cycle after rd_gnt
//   mem_wr_en/mem_wr_addr/mem_din : SRAM write port
//   mem_rd_en/mem_rd_addr/mem_dout: SRAM read port (registered read data)
module sram_port_arbiter #(
   parameter int N_PORTS = 4,
   parameter int ADDR_W  = sram_pkg::ADDR_W,
   parameter int DATA_W  = sram_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_PORTS-1:0]        wr_req,
   input  logic [N_PORTS*ADDR_W-1:0] wr_addr,
   input  logic [N_PORTS*DATA_W-1:0] wr_data,
   output logic [N_PORTS-1:0]        wr_gnt,
   input  logic [N_PORTS-1:0]        rd_req,
   input  logic [N_PORTS*ADDR_W-1:0] rd_addr,
   output logic [N_PORTS-1:0]        rd_gnt,
   output logic [N_PORTS-1:0]        rd_vld,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      mem_wr_en,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [DATA_W-1:0]         mem_din,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   input  logic [DATA_W-1:0]         mem_dout
);
   logic [N_PORTS-1:0] rd_vld_q;
   logic [N_PORTS-1:0] rd_vld_d;

   rr_arbiter #(.N(N_PORTS)) u_wr_arb (
      .clk (clk),
      .rst (rst),
      .req (wr_req),
      .gnt (wr_gnt)
   );

   rr_arbiter #(.N(N_PORTS)) u_rd_arb (
      .clk (clk),
      .rst (rst),
      .req (rd_req),
      .gnt (rd_gnt)
   );

   // Grants are one-hot, so a priority-free select is enough. With no grant,
   // address and data stay at zero.
   always_comb begin
      mem_wr_addr = '0;
      mem_din     = '0;
      mem_rd_addr = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (wr_gnt[k]) begin
            mem_wr_addr = wr_addr[k*ADDR_W +: ADDR_W];
            mem_din     = wr_data[k*DATA_W +: DATA_W];
         end
         if (rd_gnt[k]) begin
            mem_rd_addr = rd_addr[k*ADDR_W +: ADDR_W];
         end
      end
   end

   assign mem_wr_en = |wr_gnt;
   assign mem_rd_en = |rd_gnt;

   // The SRAM registers its read data, so the valid tag is the grant delayed by
   // one cycle. A read in flight when reset hits is dropped.
   always_comb begin
      rd_vld_d = rd_gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q <= '0;
      end else begin
         rd_vld_q <= rd_vld_d;
      end
   end

   assign rd_vld  = rd_vld_q;
   assign rd_data = mem_dout;
endmodule : sram_port_arbiter
